// File: rtl/spi_cmd_ctrl_if.sv
// Handshake bundle between the SPI command sequencer, the SPI word receiver/transmitter
// and the register bank. The master modport is the sequencer side.
interface spi_cmd_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_abort;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wr_data;
  logic              write_en;
  logic              read_en;
  logic [DATA_W-1:0] rd_data;
  logic              tx_req;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ack;
  logic              busy;
  logic [7:0]        err_cnt;

  modport master (
    input  rx_valid, rx_data, rx_abort, rd_data, tx_ack,
    output address, wr_data, write_en, read_en, tx_req, tx_data, busy, err_cnt
  );

  modport slave (
    output rx_valid, rx_data, rx_abort, rd_data, tx_ack,
    input  address, wr_data, write_en, read_en, tx_req, tx_data, busy, err_cnt
  );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// SPI command sequencer: decodes a command word, then runs a burst of register
// writes (one per received data word) or reads (each handed to the SPI transmitter).
module spi_cmd_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic            clk,
  input logic            reset,
  spi_cmd_ctrl_if.master bus
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT,
    RD_ISSUE,
    RD_WAIT,
    TX_WAIT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        rem;
  logic [TMR_W-1:0]  timer;
  logic [2:0]        lat_cnt;
  logic              rd_phase;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Words arriving while a read burst is in flight have nowhere to go.
  assign rd_phase = (state == RD_ISSUE) || (state == RD_WAIT) || (state == TX_WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      addr         <= '0;
      rem          <= '0;
      timer        <= '0;
      lat_cnt      <= '0;
      bus.address  <= '0;
      bus.wr_data  <= '0;
      bus.write_en <= 1'b0;
      bus.read_en  <= 1'b0;
      bus.tx_req   <= 1'b0;
      bus.tx_data  <= '0;
      bus.busy     <= 1'b0;
      bus.err_cnt  <= '0;
    end else begin
      bus.write_en <= 1'b0;
      bus.read_en  <= 1'b0;

      if (bus.rx_abort && (state != IDLE)) begin
        // Abort beats everything, including a word landing in the same cycle.
        state       <= IDLE;
        bus.busy    <= 1'b0;
        bus.tx_req  <= 1'b0;
        bus.err_cnt <= sat_inc(bus.err_cnt);
      end else begin
        case (state)
          IDLE: begin
            if (bus.rx_valid && !bus.rx_abort) begin
              addr <= ADDR_W'(bus.rx_data[7:0]);
              rem  <= bus.rx_data[11:8];
              if (bus.rx_data[14:12] != 3'b000) begin
                bus.err_cnt <= sat_inc(bus.err_cnt);
              end else if (bus.rx_data[15]) begin
                state    <= WR_WAIT;
                timer    <= '0;
                bus.busy <= 1'b1;
              end else begin
                state    <= RD_ISSUE;
                bus.busy <= 1'b1;
              end
            end
          end

          WR_WAIT: begin
            if (bus.rx_valid) begin
              bus.write_en <= 1'b1;
              bus.address  <= addr;
              bus.wr_data  <= bus.rx_data;
              addr         <= addr + ADDR_W'(1);
              timer        <= '0;
              if (rem == 4'd0) begin
                state    <= IDLE;
                bus.busy <= 1'b0;
              end else begin
                rem <= rem - 4'd1;
              end
            end else if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
              state       <= IDLE;
              bus.busy    <= 1'b0;
              bus.err_cnt <= sat_inc(bus.err_cnt);
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end

          RD_ISSUE: begin
            bus.read_en <= 1'b1;
            bus.address <= addr;
            lat_cnt     <= '0;
            state       <= RD_WAIT;
          end

          RD_WAIT: begin
            // lat_cnt starts counting in the cycle the strobe is visible.
            if (lat_cnt == 3'(RD_LAT)) begin
              bus.tx_data <= bus.rd_data;
              bus.tx_req  <= 1'b1;
              state       <= TX_WAIT;
            end else begin
              lat_cnt <= lat_cnt + 3'd1;
            end
          end

          TX_WAIT: begin
            if (bus.tx_ack) begin
              bus.tx_req <= 1'b0;
              addr       <= addr + ADDR_W'(1);
              if (rem == 4'd0) begin
                state    <= IDLE;
                bus.busy <= 1'b0;
              end else begin
                rem   <= rem - 4'd1;
                state <= RD_ISSUE;
              end
            end
          end

          default: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        endcase

        if (bus.rx_valid && rd_phase) begin
          bus.err_cnt <= sat_inc(bus.err_cnt);
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: directed scenarios plus randomized bursts checked against
// a transaction-level model of the command protocol.
module tb_spi_cmd_ctrl;
  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 16;
  localparam int RD_LAT      = 2;
  localparam int TIMEOUT_CYC = 40;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_cmd_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  spi_cmd_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );

  int checks = 0;
  int failures = 0;

  logic [15:0] bank[256];
  logic [15:0] ref_mem[256];
  logic [15:0] hist[0:RD_LAT];
  logic [23:0] got_wr[$], exp_wr[$];
  logic [7:0]  got_rd[$], exp_rd[$];
  logic [15:0] got_tx[$], exp_tx[$];
  logic [15:0] wq[$];
  int exp_err = 0;
  int cyc = 0, last_rd_cyc = -1, min_rd_gap = 1000;
  bit overlap = 0, tx_unstable = 0, ack_en = 1;
  int ack_delay = 0, ack_wait = 0;
  logic [15:0] tx_first;

  // Environment: register bank with RD_LAT read latency, transmitter ack, strobe monitor.
  initial begin
    bus.tx_ack = 1'b0;
    bus.rd_data = '0;
    for (int k = 0; k <= RD_LAT; k++) hist[k] = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.write_en) begin
        got_wr.push_back({bus.address, bus.wr_data});
        bank[bus.address] = bus.wr_data;
      end
      if (bus.read_en) begin
        got_rd.push_back(bus.address);
        if (last_rd_cyc >= 0 && (cyc - last_rd_cyc) < min_rd_gap) min_rd_gap = cyc - last_rd_cyc;
        last_rd_cyc = cyc;
      end
      if (bus.write_en && bus.read_en) overlap = 1;
      for (int k = RD_LAT; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = bus.read_en ? bank[bus.address] : 16'($urandom);
      bus.rd_data = hist[RD_LAT];
      if (bus.tx_ack || reset) begin
        bus.tx_ack = 1'b0;
        ack_wait = 0;
      end else if (bus.tx_req && ack_en) begin
        if (ack_wait == 0) tx_first = bus.tx_data;
        else if (bus.tx_data !== tx_first) tx_unstable = 1;
        if (ack_wait >= ack_delay) begin
          bus.tx_ack = 1'b1;
          got_tx.push_back(bus.tx_data);
        end else begin
          ack_wait++;
        end
      end else if (!bus.tx_req) begin
        ack_wait = 0;
      end
    end
  end

  task automatic clear_q();
    got_wr.delete(); exp_wr.delete(); got_rd.delete(); exp_rd.delete();
    got_tx.delete(); exp_tx.delete(); wq.delete();
  endtask

  task automatic bump_err();
    exp_err = (exp_err < 255) ? exp_err + 1 : 255;
  endtask

  // Protocol model: what a command plus its data words (in wq) must produce.
  task automatic model_cmd(input logic [15:0] cmd);
    logic [7:0] a;
    if (cmd[14:12] != 3'b000) begin
      bump_err();
      return;
    end
    for (int i = 0; i <= int'(cmd[11:8]); i++) begin
      a = cmd[7:0] + 8'(i);
      if (cmd[15]) begin
        exp_wr.push_back({a, wq[i]});
        ref_mem[a] = wq[i];
      end else begin
        exp_rd.push_back(a);
        exp_tx.push_back(ref_mem[a]);
      end
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data = w;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_abort(input bit with_word, input logic [15:0] w);
    @(negedge clk);
    bus.rx_abort = 1'b1;
    bus.rx_valid = with_word;
    bus.rx_data = w;
    @(negedge clk);
    bus.rx_abort = 1'b0;
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.rx_valid = 1'b0; bus.rx_abort = 1'b0; bus.rx_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.err_cnt !== 8'd0) begin failures++; $display("FAIL reset_err got=%0d exp=0", bus.err_cnt); end
    checks++; if (bus.tx_req !== 1'b0) begin failures++; $display("FAIL reset_tx_req got=%b exp=0", bus.tx_req); end
    checks++; if ({bus.write_en, bus.read_en} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b exp=00", {bus.write_en, bus.read_en}); end
    checks++; if ({bus.address, bus.wr_data, bus.tx_data} !== 40'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", {bus.address, bus.wr_data, bus.tx_data}); end
  endtask

  task automatic test_single_write();
    clear_q();
    send_word(16'h8012);
    send_word(16'hBEEF);
    checks++; if ({bus.write_en, bus.address, bus.wr_data} !== {1'b1, 8'h12, 16'hBEEF})
      begin failures++; $display("FAIL single_write got=%b/%h/%h exp=1/12/beef", bus.write_en, bus.address, bus.wr_data); end
    @(negedge clk);
    checks++; if ({bus.write_en, bus.busy} !== 2'b00) begin failures++; $display("FAIL single_after got we/busy=%b exp=00", {bus.write_en, bus.busy}); end
    checks++; if (bus.err_cnt !== 8'd0) begin failures++; $display("FAIL single_err got=%0d exp=0", bus.err_cnt); end
    checks++; if (got_wr.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", got_wr.size()); end
    ref_mem[8'h12] = 16'hBEEF;
  endtask

  task automatic test_burst_wrap();
    bit ok;
    logic [23:0] want[3];
    want[0] = 24'hFE1111; want[1] = 24'hFF2222; want[2] = 24'h003333;
    clear_q();
    send_word(16'h82FE);
    send_word(16'h1111);
    send_word(16'h2222);
    send_word(16'h3333);
    wait_idle(20, ok);
    checks++; if (!ok || got_wr.size() != 3) begin failures++; $display("FAIL burst_count got=%0d exp=3 idle=%b", got_wr.size(), ok); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (got_wr[i] !== want[i]) begin failures++; $display("FAIL burst_wr%0d got=%h exp=%h", i, got_wr[i], want[i]); end
    end
    for (int i = 0; i < 3; i++) ref_mem[want[i][23:16]] = want[i][15:0];
  endtask

  task automatic test_read();
    bit ok;
    clear_q();
    bank[8'h40] = 16'hA5A5; ref_mem[8'h40] = 16'hA5A5;
    bank[8'h41] = 16'h5A5A; ref_mem[8'h41] = 16'h5A5A;
    ack_delay = 5; tx_unstable = 0; min_rd_gap = 1000; last_rd_cyc = -1;
    send_word(16'h0140);
    wait_idle(100, ok);
    checks++; if (!ok || got_rd.size() != 2) begin failures++; $display("FAIL read_count got=%0d exp=2 idle=%b", got_rd.size(), ok); end
    else begin
      checks++; if ({got_rd[0], got_rd[1]} !== 16'h4041) begin failures++; $display("FAIL read_addr got=%h exp=4041", {got_rd[0], got_rd[1]}); end
    end
    checks++; if (got_tx.size() != 2) begin failures++; $display("FAIL read_tx_count got=%0d exp=2", got_tx.size()); end
    else begin
      checks++; if ({got_tx[0], got_tx[1]} !== 32'hA5A55A5A) begin failures++; $display("FAIL read_tx got=%h exp=a5a55a5a", {got_tx[0], got_tx[1]}); end
    end
    checks++; if (tx_unstable) begin failures++; $display("FAIL read_tx_hold got=changed exp=stable"); end
    checks++; if (min_rd_gap < RD_LAT + 2) begin failures++; $display("FAIL read_gap got=%0d exp>=%0d", min_rd_gap, RD_LAT + 2); end
    ack_delay = 0;
  endtask

  task automatic test_reserved();
    bit ok;
    clear_q();
    send_word(16'h9000); bump_err();
    @(negedge clk);
    checks++; if ({bus.busy, bus.err_cnt} !== {1'b0, 8'(exp_err)}) begin failures++; $display("FAIL reserved got busy=%b err=%0d exp busy=0 err=%0d", bus.busy, bus.err_cnt, exp_err); end
    checks++; if (got_wr.size() + got_rd.size() != 0) begin failures++; $display("FAIL reserved_strobes got=%0d exp=0", got_wr.size() + got_rd.size()); end
    wq.push_back(16'h7777);
    model_cmd(16'h8033);
    send_word(16'h8033);
    send_word(16'h7777);
    wait_idle(10, ok);
    checks++; if (got_wr.size() != 1 || got_wr[0] !== exp_wr[0]) begin failures++; $display("FAIL reserved_next got=%0d exp=%h", got_wr.size(), exp_wr[0]); end
  endtask

  task automatic test_abort();
    clear_q();
    send_word(16'h8210);
    send_word(16'h0001);
    pulse_abort(1'b0, 16'h0);
    bump_err();
    checks++; if ({bus.busy, bus.err_cnt} !== {1'b0, 8'(exp_err)}) begin failures++; $display("FAIL abort_state got busy=%b err=%0d exp busy=0 err=%0d", bus.busy, bus.err_cnt, exp_err); end
    repeat (3) @(negedge clk);
    checks++; if (got_wr.size() != 1 || got_wr[0] !== 24'h100001) begin failures++; $display("FAIL abort_writes got=%0d exp=1 at 10", got_wr.size()); end
    ref_mem[8'h10] = 16'h0001;
    clear_q();
    send_word(16'h8210);
    pulse_abort(1'b1, 16'h5555);
    bump_err();
    repeat (2) @(negedge clk);
    checks++; if (got_wr.size() != 0 || bus.busy !== 1'b0) begin failures++; $display("FAIL abort_with_word got writes=%0d busy=%b exp 0/0", got_wr.size(), bus.busy); end
    pulse_abort(1'b0, 16'h0);
    @(negedge clk);
    checks++; if (bus.err_cnt !== 8'(exp_err)) begin failures++; $display("FAIL abort_idle got=%0d exp=%0d", bus.err_cnt, exp_err); end
  endtask

  task automatic test_timeout();
    clear_q();
    send_word(16'h8005);
    repeat (TIMEOUT_CYC - 2) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL timeout_early got busy=%b exp=1", bus.busy); end
    repeat (3) @(negedge clk);
    bump_err();
    checks++; if ({bus.busy, bus.err_cnt} !== {1'b0, 8'(exp_err)}) begin failures++; $display("FAIL timeout got busy=%b err=%0d exp busy=0 err=%0d", bus.busy, bus.err_cnt, exp_err); end
    checks++; if (got_wr.size() != 0) begin failures++; $display("FAIL timeout_writes got=%0d exp=0", got_wr.size()); end
  endtask

  task automatic test_rx_during_read();
    bit ok;
    int n;
    clear_q();
    ack_en = 0;
    model_cmd(16'h0033);
    send_word(16'h0033);
    n = 0;
    while (!bus.tx_req && n < 30) begin @(negedge clk); n++; end
    checks++; if (!bus.tx_req) begin failures++; $display("FAIL rxrd_req got=0 exp=1"); end
    send_word(16'h1234); bump_err();
    ack_en = 1;
    wait_idle(30, ok);
    checks++; if (!ok || got_tx.size() != 1 || got_tx[0] !== exp_tx[0]) begin failures++; $display("FAIL rxrd_tx got=%0d words exp=%h", got_tx.size(), exp_tx[0]); end
    checks++; if (bus.err_cnt !== 8'(exp_err)) begin failures++; $display("FAIL rxrd_err got=%0d exp=%0d", bus.err_cnt, exp_err); end
  endtask

  task automatic test_random();
    bit ok;
    logic [15:0] cmd;
    clear_q();
    min_rd_gap = 1000; last_rd_cyc = -1; overlap = 0; tx_unstable = 0;
    for (int t = 0; t < 40; t++) begin
      cmd = {1'($urandom), 3'b000, 4'($urandom_range(0, 3)), 8'($urandom)};
      if ($urandom_range(0, 7) == 0) cmd[14:12] = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 9) == 0) cmd[11:8] = 4'($urandom_range(4, 15));
      wq.delete();
      for (int i = 0; i <= int'(cmd[11:8]); i++) wq.push_back(16'($urandom));
      ack_delay = $urandom_range(0, 3);
      model_cmd(cmd);
      send_word(cmd);
      if (cmd[15] && cmd[14:12] == 3'b000) begin
        foreach (wq[i]) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          send_word(wq[i]);
        end
      end
      wait_idle(300, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rand_idle txn=%0d cmd=%h got busy=1 exp=0", t, cmd); end
    end
    checks++; if (got_wr.size() != exp_wr.size()) begin failures++; $display("FAIL rand_wr_count got=%0d exp=%0d", got_wr.size(), exp_wr.size()); end
    else foreach (exp_wr[i]) begin
      checks++; if (got_wr[i] !== exp_wr[i]) begin failures++; $display("FAIL rand_wr%0d got=%h exp=%h", i, got_wr[i], exp_wr[i]); end
    end
    checks++; if (got_rd.size() != exp_rd.size()) begin failures++; $display("FAIL rand_rd_count got=%0d exp=%0d", got_rd.size(), exp_rd.size()); end
    else foreach (exp_rd[i]) begin
      checks++; if (got_rd[i] !== exp_rd[i]) begin failures++; $display("FAIL rand_rd%0d got=%h exp=%h", i, got_rd[i], exp_rd[i]); end
    end
    checks++; if (got_tx.size() != exp_tx.size()) begin failures++; $display("FAIL rand_tx_count got=%0d exp=%0d", got_tx.size(), exp_tx.size()); end
    else foreach (exp_tx[i]) begin
      checks++; if (got_tx[i] !== exp_tx[i]) begin failures++; $display("FAIL rand_tx%0d got=%h exp=%h", i, got_tx[i], exp_tx[i]); end
    end
    checks++; if (overlap || tx_unstable) begin failures++; $display("FAIL rand_protocol got overlap=%b unstable=%b exp 0/0", overlap, tx_unstable); end
    checks++; if (min_rd_gap < RD_LAT + 2) begin failures++; $display("FAIL rand_rd_gap got=%0d exp>=%0d", min_rd_gap, RD_LAT + 2); end
    checks++; if (bus.err_cnt !== 8'(exp_err)) begin failures++; $display("FAIL rand_err got=%0d exp=%0d", bus.err_cnt, exp_err); end
    ack_delay = 0;
  endtask

  task automatic test_err_saturation();
    clear_q();
    for (int i = 0; i < 260; i++) begin
      send_word({1'($urandom), 3'b111, 12'($urandom)});
      bump_err();
    end
    @(negedge clk);
    checks++; if (bus.err_cnt !== 8'(exp_err) || exp_err != 255) begin failures++; $display("FAIL err_sat got=%0d exp=255", bus.err_cnt); end
    checks++; if (got_wr.size() + got_rd.size() != 0) begin failures++; $display("FAIL err_sat_strobes got=%0d exp=0", got_wr.size() + got_rd.size()); end
  endtask

  task automatic test_reset_mid_tx();
    int n;
    ack_en = 0;
    send_word(16'h0150);
    n = 0;
    while (!bus.tx_req && n < 30) begin @(negedge clk); n++; end
    checks++; if (!bus.tx_req) begin failures++; $display("FAIL rst_tx_req_before got=0 exp=1"); end
    #2 reset = 1'b1;
    #1;
    exp_err = 0;
    checks++; if ({bus.tx_req, bus.busy, bus.err_cnt} !== 10'd0) begin failures++; $display("FAIL rst_mid_tx got req=%b busy=%b err=%0d exp 0/0/0", bus.tx_req, bus.busy, bus.err_cnt); end
    @(negedge clk);
    reset = 1'b0;
    ack_en = 1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      bank[i] = 16'($urandom);
      ref_mem[i] = bank[i];
    end
    test_reset();
    test_single_write();
    test_burst_wrap();
    test_read();
    test_reserved();
    test_abort();
    test_timeout();
    test_rx_during_read();
    test_random();
    test_err_saturation();
    test_reset_mid_tx();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end
endmodule

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
- Command sequencer between the 16-bit SPI word receiver and the register bank.
- Takes received 16-bit words and decodes a command word: direction, burst length, start address.
- Write commands: issues one register write per following data word.
- Read commands: issues register reads and hands each result to the SPI transmitter with a req/ack handshake.
- Auto-increments the address across a burst and counts protocol errors.

Parameters:
- ADDR_W, 8, register address width.
- DATA_W, 16, word width; must equal the receiver word width.
- RD_LAT, 1, cycles from read_en to valid rd_data (legal range 1..7).
- TIMEOUT_CYC, 1000, max clk cycles waiting for a write data word before abort.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- rx_valid  in  1  one-cycle pulse: rx_data holds a complete received word.
- rx_data  in  DATA_W  received word.
- rx_abort  in  1  one-cycle pulse: ssn deasserted before the frame completed.
- address  out  ADDR_W  register address for write_en/read_en.
- wr_data  out  DATA_W  register write data.
- write_en  out  1  one-cycle register write strobe.
- read_en  out  1  one-cycle register read strobe.
- rd_data  in  DATA_W  register read data, valid RD_LAT cycles after read_en.
- tx_req  out  1  level: tx_data valid, held until tx_ack.
- tx_data  out  DATA_W  word to transmit.
- tx_ack  in  1  one-cycle pulse: transmitter accepted tx_data.
- busy  out  1  high whenever state != IDLE.
- err_cnt  out  8  saturating protocol-error counter.

Behaviour:
- Clocking and reset: reset is asynchronous, active-high; clock is clk. All outputs are registered. On reset, all outputs are 0 and the state is IDLE.
- Command word format:
  - bit15 = dir (1 write, 0 read).
  - bits14:12 reserved, must be 0.
  - bits11:8 = len (burst of len+1 words, 1..16).
  - bits7:0 = start address.
- IDLE: on rx_valid, latch addr, rem = len, dir.
  - If reserved bits are non-zero: err_cnt += 1, stay in IDLE.
  - Else if dir = 1: go to WR_WAIT and clear the timer.
  - Else: go to RD_ISSUE.
- WR_WAIT: on rx_valid, next cycle write_en = 1 for one cycle, with address = addr and wr_data = rx_data.
  - Then addr += 1 (wraps modulo 2^ADDR_W) and the timer clears.
  - If rem == 0, go to IDLE; else rem -= 1 and stay.
  - Timer increments every cycle without rx_valid. When it reaches TIMEOUT_CYC: err_cnt += 1, go to IDLE.
- RD_ISSUE: read_en = 1 for one cycle with address = addr, then go to RD_WAIT.
- RD_WAIT: counts RD_LAT cycles, then captures rd_data into tx_data and asserts tx_req; go to TX_WAIT.
- TX_WAIT: tx_req and tx_data hold until tx_ack.
  - On tx_ack: tx_req = 0 next cycle, addr += 1 (wrap).
  - If rem == 0, go to IDLE; else rem -= 1 and go to RD_ISSUE.
  - Back-to-back reads: read_en pulses are spaced at least RD_LAT+2 cycles apart.
- rx_valid in RD_ISSUE, RD_WAIT or TX_WAIT: word discarded, err_cnt += 1.
- rx_abort in any non-IDLE state: go to IDLE next cycle, tx_req cleared, err_cnt += 1. No further write_en/read_en is issued.
- rx_abort in IDLE: ignored, no error.
- Simultaneous rx_valid and rx_abort: abort wins, the word is discarded, and no write_en is issued.
- err_cnt saturates at 255 and is cleared only by reset.
- address and wr_data hold their last values between strobes.
- write_en and read_en are never high in the same cycle.

Test Plan:
- Write 0x8012 then 0xBEEF -> one write_en pulse with address = 0x12, wr_data = 0xBEEF; busy low one cycle after the strobe; err_cnt = 0.
- Burst write 0x82FE, then 0x1111, 0x2222, 0x3333 -> writes to 0xFE, 0xFF, 0x00 (address wraps) with the matching data; then IDLE.
- Read 0x0140 with RD_LAT = 2; rd_data = 0xA5A5 at 0x40 and 0x5A5A at 0x41; tx_ack delayed 5 cycles -> read_en at 0x40, tx_req holds 0xA5A5 until ack, then read_en at 0x41, tx_data = 0x5A5A.
- Command 0x9000 (reserved bit12 set) -> no strobes, err_cnt = 1, stays IDLE. The next valid command executes normally.
- 0x8210 then 0x0001, then rx_abort -> one write at 0x10 only; IDLE; err_cnt = 1. rx_valid and rx_abort in the same cycle in WR_WAIT -> no write_en.
- 0x8005 then no data for TIMEOUT_CYC cycles -> IDLE, err_cnt += 1, no write_en. Reset asserted mid TX_WAIT -> tx_req = 0 immediately.
